// File: rtl/control_pipe.sv
// Control-path pipeline for the 5-stage core: carries the decoded control bundle through
// ID/EX, EX/MEM and MEM/WB, and generates load-use stalls, redirect flushes and forwarding selects.
module control_pipe #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CTRL_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              flush_if_id,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic [REG_W-1:0]  mem_rd,
    output logic [REG_W-1:0]  wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    // Bundle layout, MSB first: {jump[1:0], branch, mem_read, mem_to_reg, alu_op[1:0],
    // mem_write, alu_src, reg_write}
    localparam int unsigned JumpHi   = 9;
    localparam int unsigned JumpLo   = 8;
    localparam int unsigned Branch   = 7;
    localparam int unsigned MemRead  = 6;
    localparam int unsigned MemWrite = 2;
    localparam int unsigned AluSrc   = 1;
    localparam int unsigned RegWrite = 0;

    localparam logic [1:0] FwdReg = 2'b00;
    localparam logic [1:0] FwdMem = 2'b10;
    localparam logic [1:0] FwdWb  = 2'b01;

    logic              ex_valid_q,  ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;
    logic [REG_W-1:0]  ex_rs1_q,    ex_rs1_d;
    logic [REG_W-1:0]  ex_rs2_q,    ex_rs2_d;
    logic [REG_W-1:0]  ex_rd_q,     ex_rd_d;
    logic              mem_valid_q;
    logic [CTRL_W-1:0] mem_ctrl_q;
    logic [REG_W-1:0]  mem_rd_q;
    logic              wb_valid_q;
    logic [CTRL_W-1:0] wb_ctrl_q;
    logic [REG_W-1:0]  wb_rd_q;

    logic [1:0] id_jump;
    logic       rs1_used;
    logic       rs2_used;
    logic       hazard;
    logic       mem_writes_reg;
    logic       wb_writes_reg;

    // Which sources the ID instruction really reads; JAL reads neither, I-type skips rs2.
    always_comb begin
        id_jump  = id_ctrl[JumpHi:JumpLo];
        rs1_used = id_valid & (id_jump != 2'b01);
        rs2_used = id_valid & (id_ctrl[MemWrite] |
                   (~id_ctrl[AluSrc] & (id_jump == 2'b00) &
                    (id_ctrl[RegWrite] | id_ctrl[Branch])));
    end

    always_comb begin
        hazard = ex_valid_q & ex_ctrl_q[MemRead] & (ex_rd_q != '0) &
                 ((rs1_used & (ex_rd_q == id_rs1)) | (rs2_used & (ex_rd_q == id_rs2)));
        stall       = hazard & ~ex_redirect;
        flush_if_id = ex_redirect;
    end

    // Redirect and load-use both insert a bubble; an invalid ID slot is zeroed the same way.
    always_comb begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
        ex_rs1_d   = '0;
        ex_rs2_d   = '0;
        ex_rd_d    = '0;
        if (!ex_redirect && !hazard && id_valid) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = id_ctrl;
            ex_rs1_d   = id_rs1;
            ex_rs2_d   = id_rs2;
            ex_rd_d    = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= '0;
            wb_rd_q     <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rd_q     <= ex_rd_d;
            mem_valid_q <= ex_valid_q;
            mem_ctrl_q  <= ex_ctrl_q;
            mem_rd_q    <= ex_rd_q;
            wb_valid_q  <= mem_valid_q;
            wb_ctrl_q   <= mem_ctrl_q;
            wb_rd_q     <= mem_rd_q;
        end
    end

    // x0 is hardwired, so a write to it must never be forwarded.
    always_comb begin
        mem_writes_reg = mem_valid_q & mem_ctrl_q[RegWrite] & (mem_rd_q != '0);
        wb_writes_reg  = wb_valid_q & wb_ctrl_q[RegWrite] & (wb_rd_q != '0);

        fwd_a = FwdReg;
        if (mem_writes_reg && (mem_rd_q == ex_rs1_q)) begin
            fwd_a = FwdMem;
        end else if (wb_writes_reg && (wb_rd_q == ex_rs1_q)) begin
            fwd_a = FwdWb;
        end

        fwd_b = FwdReg;
        if (mem_writes_reg && (mem_rd_q == ex_rs2_q)) begin
            fwd_b = FwdMem;
        end else if (wb_writes_reg && (wb_rd_q == ex_rs2_q)) begin
            fwd_b = FwdWb;
        end
    end

    always_comb begin
        ex_valid  = ex_valid_q;
        ex_ctrl   = ex_ctrl_q;
        ex_rs1    = ex_rs1_q;
        ex_rs2    = ex_rs2_q;
        ex_rd     = ex_rd_q;
        mem_valid = mem_valid_q;
        mem_ctrl  = mem_ctrl_q;
        mem_rd    = mem_rd_q;
        wb_valid  = wb_valid_q;
        wb_ctrl   = wb_ctrl_q;
        wb_rd     = wb_rd_q;
    end

endmodule
